// File: rtl/commit_trace_serializer.sv
// Compacts sparse commit slots into an in-order one-per-cycle trace FIFO.
// Define COMMIT_TRACE_SEQ_EN to add the 32-bit trace sequence counter.
module commit_trace_serializer #(
  parameter int RETIRE_W = 8,
  parameter int DEPTH    = 16,
  parameter int XLEN     = 64,
  parameter int ADDR_W   = 40
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [RETIRE_W-1:0]        commit_valid,
  output logic                       commit_ready,
  input  logic [RETIRE_W*ADDR_W-1:0] commit_pc,
  input  logic [RETIRE_W*32-1:0]     commit_inst,
  input  logic [RETIRE_W*5-1:0]      commit_ldst,
  input  logic [RETIRE_W*3-1:0]      commit_rtype,
  input  logic [RETIRE_W*XLEN-1:0]   commit_wdata,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [ADDR_W-1:0]          trace_pc,
  output logic [31:0]                trace_inst,
  output logic [4:0]                 trace_ldst,
  output logic [2:0]                 trace_rtype,
  output logic [XLEN-1:0]            trace_wdata,
  output logic [31:0]                trace_seq,
  output logic                       overflow_err,
  output logic [15:0]                drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] r_pc    [DEPTH];
  logic [31:0]       r_inst  [DEPTH];
  logic [4:0]        r_ldst  [DEPTH];
  logic [2:0]        r_rtype [DEPTH];
  logic [XLEN-1:0]   r_wdata [DEPTH];

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [15:0]   r_drop;

  logic [PW-1:0] w_off [RETIRE_W];
  logic [CW-1:0] w_npush;
  logic          w_any;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic [16:0]   w_dsum;

  // w_off[i] = number of valid slots below slot i
  always_comb begin
    w_npush = '0;
    for (int i = 0; i < RETIRE_W; i++) begin
      w_off[i] = w_npush[PW-1:0];
      w_npush  = w_npush + CW'(commit_valid[i]);
    end
  end

  assign commit_ready = (r_count <= CW'(DEPTH - RETIRE_W));
  assign trace_valid  = (r_count != '0);
  assign w_any        = |commit_valid;
  assign w_push       = commit_ready & w_any & ~flush;
  assign w_pop        = trace_valid & trace_ready & ~flush;
  assign w_drop       = w_any & ~commit_ready;
  assign w_dsum       = {1'b0, r_drop} + 17'(w_npush);

  always_ff @(posedge clock) begin
    if (w_push) begin
      for (int i = 0; i < RETIRE_W; i++) begin
        if (commit_valid[i]) begin
          r_pc[r_wr_ptr + w_off[i]]    <= commit_pc[i*ADDR_W +: ADDR_W];
          r_inst[r_wr_ptr + w_off[i]]  <= commit_inst[i*32 +: 32];
          r_ldst[r_wr_ptr + w_off[i]]  <= commit_ldst[i*5 +: 5];
          r_rtype[r_wr_ptr + w_off[i]] <= commit_rtype[i*3 +: 3];
          r_wdata[r_wr_ptr + w_off[i]] <= commit_wdata[i*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + w_npush[PW-1:0];
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + (w_push ? w_npush : '0) - CW'(w_pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else if (w_drop) begin
      r_ovf  <= 1'b1;
      r_drop <= w_dsum[16] ? 16'hFFFF : w_dsum[15:0];
    end
  end

`ifdef COMMIT_TRACE_SEQ_EN
  logic [31:0] r_seq;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_seq <= '0;
    else if (w_pop)
      r_seq <= r_seq + 32'd1;
  end

  assign trace_seq = r_seq;
`else
  assign trace_seq = '0;
`endif

  assign trace_pc     = r_pc[r_rd_ptr];
  assign trace_inst   = r_inst[r_rd_ptr];
  assign trace_ldst   = r_ldst[r_rd_ptr];
  assign trace_rtype  = r_rtype[r_rd_ptr];
  assign trace_wdata  = r_wdata[r_rd_ptr];
  assign overflow_err = r_ovf;
  assign drop_cnt     = r_drop;

endmodule
